// File: rtl/game_match_tracker.sv
// Best-of-N match tracker: scores per-game results from the flags controller,
// declares the match winner through a valid/ack handshake and keeps statistics.
module game_match_tracker #(
  parameter int GAMES_TO_WIN = 3,
  parameter int SCORE_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gameover,
  input  logic [1:0]         who,
  input  logic               match_ack,
  output logic               match_valid,
  output logic [1:0]         match_who,
  output logic [SCORE_W-1:0] win_games,
  output logic [SCORE_W-1:0] lose_games,
  output logic [7:0]         matches_played,
  output logic [1:0]         streak_who,
  output logic [3:0]         streak_len,
  output logic [3:0]         missed,
  output logic               err_who
);

  localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(GAMES_TO_WIN);

  typedef enum logic {PLAY = 1'b0, DONE = 1'b1} state_t;

  state_t             state, state_next;
  logic               gameover_d;
  logic               game_event;
  logic               legal;
  logic               win_side;
  logic [SCORE_W-1:0] score_inc;

  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    return (val == 4'd15) ? val : val + 4'd1;
  endfunction

  always_comb begin
    game_event = gameover & ~gameover_d;
    legal      = (who == 2'b01) || (who == 2'b10);
    win_side   = (who == 2'b10);
    score_inc  = win_side ? win_games + SCORE_W'(1) : lose_games + SCORE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PLAY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PLAY: if (game_event && legal && score_inc == TARGET) state_next = DONE;
      DONE: if (match_ack) state_next = PLAY;
      default: state_next = PLAY;
    endcase
  end

  // match_valid is a decode of the state register, so it stays registered.
  always_comb begin
    match_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gameover_d     <= 1'b0;
      match_who      <= 2'b00;
      win_games      <= '0;
      lose_games     <= '0;
      matches_played <= 8'd0;
      streak_who     <= 2'b00;
      streak_len     <= 4'd0;
      missed         <= 4'd0;
      err_who        <= 1'b0;
    end else begin
      gameover_d <= gameover;
      if (game_event && !legal) err_who <= 1'b1;
      if (state == PLAY) begin
        if (game_event && legal) begin
          if (win_side) win_games  <= score_inc;
          else          lose_games <= score_inc;
          if (streak_who == who) begin
            streak_len <= sat_inc4(streak_len);
          end else begin
            streak_who <= who;
            streak_len <= 4'd1;
          end
          if (score_inc == TARGET) match_who <= who;
        end
      end else begin
        // A colliding event is counted as missed, never scored in the new match.
        if (game_event && legal) missed <= sat_inc4(missed);
        if (match_ack) begin
          win_games      <= '0;
          lose_games     <= '0;
          streak_who     <= 2'b00;
          streak_len     <= 4'd0;
          match_who      <= 2'b00;
          matches_played <= matches_played + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_match_tracker.sv
// Directed self-checking bench for game_match_tracker (GAMES_TO_WIN = 3).
module tb_game_match_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       gameover;
  logic [1:0] who;
  logic       match_ack;
  logic       match_valid;
  logic [1:0] match_who;
  logic [2:0] win_games;
  logic [2:0] lose_games;
  logic [7:0] matches_played;
  logic [1:0] streak_who;
  logic [3:0] streak_len;
  logic [3:0] missed;
  logic       err_who;

  int checks = 0;
  int errors = 0;

  game_match_tracker #(.GAMES_TO_WIN(3), .SCORE_W(3)) dut (
    .clk(clk), .rst(rst), .gameover(gameover), .who(who), .match_ack(match_ack),
    .match_valid(match_valid), .match_who(match_who), .win_games(win_games),
    .lose_games(lose_games), .matches_played(matches_played),
    .streak_who(streak_who), .streak_len(streak_len), .missed(missed),
    .err_who(err_who)
  );

  always #5 clk = ~clk;

  task automatic pulse(input logic [1:0] w);
    @(negedge clk);
    gameover = 1'b1;
    who      = w;
    @(negedge clk);
    gameover = 1'b0;
    who      = 2'b00;
  endtask

  task automatic ack();
    @(negedge clk);
    match_ack = 1'b1;
    @(negedge clk);
    match_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({match_valid, match_who, win_games, lose_games, matches_played, streak_who,
         streak_len, missed, err_who} !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%0b mw=%0b w=%0d l=%0d mp=%0d sw=%0b sl=%0d m=%0d e=%0b, need all 0",
               match_valid, match_who, win_games, lose_games, matches_played, streak_who,
               streak_len, missed, err_who);
    end
  endtask

  task automatic test_first_match();
    for (int i = 1; i <= 3; i++) begin
      pulse(2'b10);
      checks++;
      if (win_games !== 3'(i)) begin
        errors++; $display("FAIL t1_win_games: got %0d need %0d", win_games, i);
      end
      checks++;
      if (match_valid !== (i == 3)) begin
        errors++; $display("FAIL t1_match_valid: got %0b need %0b after pulse %0d", match_valid, (i == 3), i);
      end
      repeat (2) @(negedge clk);
    end
    checks++;
    if (match_who !== 2'b10 || streak_who !== 2'b10 || streak_len !== 4'd3) begin
      errors++;
      $display("FAIL t1_result: got mw=%0b sw=%0b sl=%0d need mw=10 sw=10 sl=3", match_who, streak_who, streak_len);
    end
    ack();
    checks++;
    if (match_valid !== 1'b0 || matches_played !== 8'd1 || win_games !== 3'd0 || streak_len !== 4'd0) begin
      errors++;
      $display("FAIL t1_ack: got v=%0b mp=%0d w=%0d sl=%0d need v=0 mp=1 w=0 sl=0",
               match_valid, matches_played, win_games, streak_len);
    end
  endtask

  task automatic test_level_held();
    @(negedge clk);
    gameover = 1'b1;
    who      = 2'b01;
    repeat (5) @(negedge clk);
    gameover = 1'b0;
    who      = 2'b00;
    @(negedge clk);
    checks++;
    if (lose_games !== 3'd1 || streak_who !== 2'b01 || streak_len !== 4'd1) begin
      errors++;
      $display("FAIL t2_level: got l=%0d sw=%0b sl=%0d need l=1 sw=01 sl=1", lose_games, streak_who, streak_len);
    end
  endtask

  task automatic test_alternating();
    logic [1:0] seq [5]  = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    logic [3:0] slen [5] = '{4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(seq[i]);
      checks++;
      if (streak_who !== seq[i] || streak_len !== slen[i]) begin
        errors++;
        $display("FAIL t3_streak_%0d: got %0b/%0d need %0b/%0d", i, streak_who, streak_len, seq[i], slen[i]);
      end
    end
    checks++;
    if (lose_games !== 3'd3 || win_games !== 3'd2 || match_valid !== 1'b1 || match_who !== 2'b01) begin
      errors++;
      $display("FAIL t3_result: got l=%0d w=%0d v=%0b mw=%0b need l=3 w=2 v=1 mw=01",
               lose_games, win_games, match_valid, match_who);
    end
  endtask

  task automatic test_done_events();
    pulse(2'b10);
    pulse(2'b10);
    checks++;
    if (missed !== 4'd2 || win_games !== 3'd2 || lose_games !== 3'd3 || match_valid !== 1'b1) begin
      errors++;
      $display("FAIL t4_frozen: got m=%0d w=%0d l=%0d v=%0b need m=2 w=2 l=3 v=1",
               missed, win_games, lose_games, match_valid);
    end
    @(negedge clk);
    gameover  = 1'b1;
    who       = 2'b01;
    match_ack = 1'b1;
    @(negedge clk);
    gameover  = 1'b0;
    who       = 2'b00;
    match_ack = 1'b0;
    checks++;
    if (missed !== 4'd3 || win_games !== 3'd0 || lose_games !== 3'd0 || matches_played !== 8'd1 ||
        match_valid !== 1'b0 || match_who !== 2'b00) begin
      errors++;
      $display("FAIL t4_collision: got m=%0d w=%0d l=%0d mp=%0d v=%0b mw=%0b need m=3 w=0 l=0 mp=1 v=0 mw=00",
               missed, win_games, lose_games, matches_played, match_valid, match_who);
    end
    pulse(2'b10);
    checks++;
    if (win_games !== 3'd1 || streak_who !== 2'b10 || streak_len !== 4'd1) begin
      errors++;
      $display("FAIL t4_next_score: got w=%0d sw=%0b sl=%0d need w=1 sw=10 sl=1", win_games, streak_who, streak_len);
    end
  endtask

  task automatic test_illegal_who();
    pulse(2'b11);
    checks++;
    if (err_who !== 1'b1 || win_games !== 3'd1 || lose_games !== 3'd0 || streak_len !== 4'd1) begin
      errors++;
      $display("FAIL t5_who11: got e=%0b w=%0d l=%0d sl=%0d need e=1 w=1 l=0 sl=1", err_who, win_games, lose_games, streak_len);
    end
    pulse(2'b00);
    ack();
    checks++;
    if (err_who !== 1'b1 || win_games !== 3'd1 || streak_who !== 2'b10 || streak_len !== 4'd1 ||
        missed !== 4'd3 || matches_played !== 8'd1 || match_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_stray_ack: got e=%0b w=%0d sw=%0b sl=%0d m=%0d mp=%0d v=%0b need e=1 w=1 sw=10 sl=1 m=3 mp=1 v=0",
               err_who, win_games, streak_who, streak_len, missed, matches_played, match_valid);
    end
  endtask

  task automatic test_reset_wrap();
    pulse(2'b10);
    pulse(2'b10);
    checks++;
    if (match_valid !== 1'b1) begin
      errors++; $display("FAIL t6_pre_done: got v=%0b need 1", match_valid);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int m = 1; m <= 256; m++) begin
      pulse(2'b10);
      pulse(2'b10);
      pulse(2'b10);
      if (m <= 20) pulse(2'b01);
      ack();
      if (m == 14) begin
        checks++;
        if (missed !== 4'd14) begin
          errors++; $display("FAIL t6_missed14: got %0d need 14", missed);
        end
      end
      if (m == 255) begin
        checks++;
        if (matches_played !== 8'd255) begin
          errors++; $display("FAIL t6_mp255: got %0d need 255", matches_played);
        end
      end
    end
    checks++;
    if (matches_played !== 8'd0 || missed !== 4'd15 || match_valid !== 1'b0) begin
      errors++;
      $display("FAIL t6_wrap: got mp=%0d m=%0d v=%0b need mp=0 m=15 v=0", matches_played, missed, match_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    gameover  = 1'b0;
    who       = 2'b00;
    match_ack = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_first_match();
    test_level_held();
    test_alternating();
    test_done_events();
    test_illegal_who();
    test_reset_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_match_tracker.md
# game_match_tracker

Downstream stage of the multi-mode-counter game. Consumes the per-game `gameover`/`who` result from the flags controller, keeps best-of-N match scores per side, and declares a match winner with a valid/ack handshake to the bench or host. It also reports match count, the current win streak, missed events and illegal `who` codes.

## Interface

**Parameters**
- `GAMES_TO_WIN`, default 3: games one side needs to win the match (legal range 1..7).
- `SCORE_W`, default 3: width of the per-side game-score counters; must hold `GAMES_TO_WIN`.

**Ports**
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `gameover`  in  1: game-over flag from the flags controller; may stay high for more than one cycle.
- `who`  in  2: game result, 2'b01 = LOSER side won the game, 2'b10 = WINNER side won the game.
- `match_ack`  in  1: host acknowledges the declared match result.
- `match_valid`  out  1: a match result is pending.
- `match_who`  out  2: 2'b01 or 2'b10 while `match_valid`, otherwise 2'b00.
- `win_games`  out  SCORE_W: games won by the WINNER side in the current match.
- `lose_games`  out  SCORE_W: games won by the LOSER side in the current match.
- `matches_played`  out  8: acknowledged matches; wraps 255 -> 0.
- `streak_who`  out  2: side holding the current streak; 2'b00 when there is none.
- `streak_len`  out  4: consecutive game wins by `streak_who`; saturates at 15.
- `missed`  out  4: game events dropped while in DONE; saturates at 15.
- `err_who`  out  1: sticky; set on a game event carrying an illegal `who`.

## Operation

**Event detection**
- Registered `gameover_d`. A game event is `gameover & ~gameover_d`, so it is rising-edge only.
- `who` is sampled in the same cycle as the rising edge.
- A level held high counts once. Back-to-back games need `gameover` low for at least 1 cycle between them.

**Illegal `who`**
- Event with `who` = 2'b00 or 2'b11 sets `err_who`.
- No score, streak or `missed` update.
- Applies in both states.

**State PLAY**
- Legal event, `who` = 10: `win_games`++.
- Legal event, `who` = 01: `lose_games`++.
- Streak update on each legal event:
  - Same side as `streak_who`: `streak_len`++ (saturating at 15).
  - Otherwise: `streak_who` <= `who`, `streak_len` <= 1.
- If the incremented score equals `GAMES_TO_WIN`:
  - Go to DONE.
  - `match_valid` <= 1.
  - `match_who` <= `who`.
  - Scores are updated in the same edge.

**State DONE**
- Scores and streak are frozen.
- Each legal event increments `missed` (saturating at 15).
- `match_ack` = 1 at the edge:
  - Clear `win_games`, `lose_games`, `streak_who`, `streak_len`.
  - `match_valid` <= 0, `match_who` <= 00.
  - `matches_played`++.
  - Go to PLAY.
- `missed` and `err_who` are not cleared by ack.

**Other rules**
- `match_ack` in PLAY is ignored.
- Ack and a legal event in the same DONE cycle: ack is applied and the event counts as `missed`. It is not scored in the new match.
- Only one side can score per event, so there are no simultaneous-winner cases.

## Timing

- Reset (async, immediate):
  - State PLAY.
  - All outputs 0 / 2'b00, including `err_who`, `missed`, `matches_played`.
  - `gameover_d` = 0, so `gameover` held high through reset release produces one event at the first edge.
- Latency:
  - Rising edge of `gameover` sampled at edge N: scores and streak updated after edge N.
  - A match-deciding event makes `match_valid` visible after edge N (1 cycle).
- Handshake:
  - `match_valid` and `match_who` stay stable until the ack edge.
  - They drop after that edge.
  - Earliest re-declaration is `GAMES_TO_WIN` game events later.
- All outputs are registered; none has a combinational path from an input.
- Reset asserted mid-match or in DONE: immediate return to the reset values; the pending result is lost.

## Test plan

1. **First match, WINNER side**
   - Stimulus: reset, then 3 one-cycle `gameover` pulses with `who`=10, 2 idle cycles apart.
   - Response: `win_games` 1,2,3; `match_valid`=1 and `match_who`=10 one cycle after the 3rd pulse; `streak_who`=10, `streak_len`=3.
2. **Level held high**
   - Stimulus: `gameover` held high 5 cycles with `who`=01.
   - Response: `lose_games`=1 only; `streak_len`=1.
3. **Alternating results**
   - Stimulus: pulses with `who` = 10, 01, 01, 10, 01.
   - Response: `lose_games`=3 and `match_who`=01; `win_games`=2; streak goes 10/1, 01/1, 01/2, 10/1, 01/1.
4. **Events while DONE, ack collision**
   - Stimulus: in DONE send 2 legal pulses, then a 3rd pulse in the same cycle as `match_ack`.
   - Response: `missed`=3; scores 0; `matches_played`=1; `match_valid`=0; next legal pulse scores 1.
5. **Illegal `who`, stray ack**
   - Stimulus: pulse with `who`=11, then a pulse with `who`=00, then `match_ack` in PLAY.
   - Response: `err_who`=1 and stays set; scores, streak, `missed`, `matches_played` unchanged.
6. **Reset in DONE, wrap**
   - Stimulus: assert `rst` asynchronously mid-cycle while `match_valid`=1.
   - Response: all outputs 0 immediately.
   - Stimulus: then 256 complete matches.
   - Response: `matches_played` wraps to 0; `missed` saturates at 15 when more than 15 events are dropped.
